// File: rtl/si5351_i2c_master.sv
// Single-transaction I2C master for Si5351 register access.
// One request performs either a register write (START, addr+W, reg, data, STOP)
// or a register read (START, addr+W, reg, repeated START, addr+R, 1 byte, NACK, STOP).
// Each bus cell is four quarters of CLK_DIV clocks; pads are open-drain (oe=1 pulls low).
module si5351_i2c_master #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rnw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StTxByte,
        StTxAck,
        StRStart,
        StRxByte,
        StMAck,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      qtr_q;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic            rnw_q;
    logic [6:0]      dev_q;
    logic [7:0]      reg_q;
    logic [7:0]      wd_q;
    logic [7:0]      shift_q;
    logic            samp_q;
    logic [7:0]      rd_data_q;
    logic            ack_err_q;
    logic            done_q;

    logic            accept;
    logic            active;
    logic            tick;
    logic            samp_pt;
    logic            cell_end;
    logic [7:0]      tx_byte;
    logic            tx_bit;

    assign accept   = (state_q == StIdle) && start;
    assign active   = (state_q != StIdle) && (state_q != StDone);
    assign tick     = (cnt_q == CntMax);
    assign samp_pt  = tick && (qtr_q == 2'd2);
    assign cell_end = tick && (qtr_q == 2'd3);

    // Byte currently being shifted out; index 2 is the read address on a read
    always_comb begin
        tx_byte = {dev_q, 1'b0};
        case (byte_q)
            2'd0:    tx_byte = {dev_q, 1'b0};
            2'd1:    tx_byte = reg_q;
            2'd2:    tx_byte = rnw_q ? {dev_q, 1'b1} : wd_q;
            default: tx_byte = 8'hFF;
        endcase
        tx_bit = tx_byte[3'd7 - bit_q];
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: cells advance only on the final quarter tick
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StStart;
            StStart:  if (cell_end) state_d = StTxByte;
            StTxByte: if (cell_end && bit_q == 3'd7) state_d = StTxAck;
            StTxAck: begin
                if (cell_end) begin
                    if (samp_q) begin
                        state_d = StStop;
                    end else if (byte_q == 2'd2) begin
                        state_d = rnw_q ? StRxByte : StStop;
                    end else if (byte_q == 2'd1 && rnw_q) begin
                        state_d = StRStart;
                    end else begin
                        state_d = StTxByte;
                    end
                end
            end
            StRStart: if (cell_end) state_d = StTxByte;
            StRxByte: if (cell_end && bit_q == 3'd7) state_d = StMAck;
            StMAck:   if (cell_end) state_d = StStop;
            StStop:   if (cell_end) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Pad drive per cell type and quarter; SDA only moves at a cell boundary or
    // at q2 of START/RSTART/STOP cells where SCL is deliberately high
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            StStart: begin
                scl_oe = 1'b0;
                sda_oe = qtr_q[1];
            end
            StTxByte: begin
                scl_oe = ~qtr_q[1];
                sda_oe = ~tx_bit;
            end
            StTxAck, StRxByte, StMAck: begin
                scl_oe = ~qtr_q[1];
                sda_oe = 1'b0;
            end
            StRStart: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = qtr_q[1];
            end
            StStop: begin
                scl_oe = (qtr_q == 2'd0);
                sda_oe = ~qtr_q[1];
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
        busy    = (state_q != StIdle);
        done    = done_q;
        ack_err = ack_err_q;
        rd_data = rd_data_q;
    end

    // Request latch, quarter prescaler, bit/byte counters, sampling and results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            rnw_q     <= 1'b0;
            dev_q     <= 7'd0;
            reg_q     <= 8'd0;
            wd_q      <= 8'd0;
            shift_q   <= 8'd0;
            samp_q    <= 1'b0;
            rd_data_q <= 8'd0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state_q == StDone);
            if (accept) begin
                rnw_q     <= rnw;
                dev_q     <= dev_addr;
                reg_q     <= reg_addr;
                wd_q      <= wr_data;
                ack_err_q <= 1'b0;
                cnt_q     <= '0;
                qtr_q     <= 2'd0;
                bit_q     <= 3'd0;
                byte_q    <= 2'd0;
                samp_q    <= 1'b0;
            end else if (active) begin
                if (tick) begin
                    cnt_q <= '0;
                    qtr_q <= qtr_q + 2'd1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                // Sample on the last clk of q2, while SCL has been high a full quarter
                if (samp_pt) begin
                    samp_q <= sda_in;
                    if (state_q == StRxByte) begin
                        shift_q <= {shift_q[6:0], sda_in};
                    end
                end
                if (cell_end) begin
                    case (state_q)
                        StTxByte, StRxByte: bit_q <= bit_q + 3'd1;
                        StTxAck: begin
                            byte_q <= byte_q + 2'd1;
                            if (samp_q) begin
                                ack_err_q <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (state_q == StDone && rnw_q && !ack_err_q) begin
                rd_data_q <= shift_q;
            end
        end
    end

endmodule

// File: tb/tb_si5351_i2c_master.sv
// Bench for si5351_i2c_master: a behavioural I2C slave decodes the bus into
// tokens (START, STOP, master-sent bytes, master ACK/NACK) which are checked
// against an expected-token queue filled when each request is issued.
module tb_si5351_i2c_master;

    localparam int unsigned CLK_DIV = 2;
    localparam int TokStart = 256;
    localparam int TokStop  = 257;
    localparam int TokMNack = 258;
    localparam int TokMAck  = 259;
    localparam int LatWrite = 29 * 4 * CLK_DIV + 1;
    localparam int LatRead  = 39 * 4 * CLK_DIV + 1;
    localparam int LatNack  = 11 * 4 * CLK_DIV + 1;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       rnw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;

    logic scl_line;
    logic sda_line;
    logic slv_pull;

    int exp_q[$];
    int obs_q[$];
    int passed;
    int total;

    // Slave configuration written by the test tasks
    int       nack_idx;
    logic [7:0] rd_byte;

    si5351_i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .rnw      (rnw),
        .dev_addr (dev_addr),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .sda_in   (sda_in),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign scl_line = ~scl_oe;
    assign sda_line = ~(sda_oe | slv_pull);
    assign sda_in   = sda_line;

    // Slave and bus decoder, evaluated mid-cycle
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitcnt   = 0;
    int         byte_idx = 0;
    bit         slave_tx = 1'b0;
    bit         pend_tx  = 1'b0;
    logic [7:0] shreg    = 8'd0;
    initial slv_pull = 1'b0;

    always @(negedge clk) begin
        if (prev_scl === 1'b1 && scl_line === 1'b1 && prev_sda === 1'b1 && sda_line === 1'b0) begin
            obs_q.push_back(TokStart);
            bitcnt = 0; byte_idx = 0; slave_tx = 0; pend_tx = 0; slv_pull = 1'b0;
        end else if (prev_scl === 1'b1 && scl_line === 1'b1 && prev_sda === 1'b0
                     && sda_line === 1'b1) begin
            obs_q.push_back(TokStop);
            bitcnt = 0; slave_tx = 0; pend_tx = 0; slv_pull = 1'b0;
        end else if (prev_scl === 1'b0 && scl_line === 1'b1) begin
            if (bitcnt < 8) shreg = {shreg[6:0], sda_line};
            else if (bitcnt == 8 && slave_tx) obs_q.push_back(sda_line ? TokMNack : TokMAck);
            if (bitcnt < 15) bitcnt++;
        end else if (prev_scl === 1'b1 && scl_line === 1'b0) begin
            if (bitcnt == 8) begin
                if (!slave_tx) begin
                    obs_q.push_back(int'(shreg));
                    slv_pull = (byte_idx != nack_idx);
                    if (byte_idx == 0 && shreg[0] && byte_idx != nack_idx) pend_tx = 1;
                end else begin
                    slv_pull = 1'b0;
                end
            end else if (bitcnt == 9) begin
                bitcnt = 0;
                byte_idx++;
                if (pend_tx) begin
                    pend_tx  = 0;
                    slave_tx = 1;
                    slv_pull = ~rd_byte[7];
                end else begin
                    slave_tx = 0;
                    slv_pull = 1'b0;
                end
            end else if (slave_tx && bitcnt < 8) begin
                slv_pull = ~rd_byte[7 - bitcnt];
            end
        end
        prev_scl = scl_line;
        prev_sda = sda_line;
    end

    // Issue one request; returns just after the accept edge
    task automatic kick(input bit r, input logic [6:0] d, input logic [7:0] ra,
                        input logic [7:0] wd);
        @(negedge clk);
        start = 1'b1; rnw = r; dev_addr = d; reg_addr = ra; wr_data = wd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Count clks from the accept edge until done is seen (bounded)
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            lat++;
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        total++; if (scl_oe !== 1'b0) $display("FAIL reset_scl_oe got %b want 0", scl_oe);
                 else passed++;
        total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b want 0", sda_oe);
                 else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
                 else passed++;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
                 else passed++;
        total++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err got %b want 0", ack_err);
                 else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data got %h want 00", rd_data);
                 else passed++;
    endtask

    task automatic test_write;
        int lat; bit seen; int e; int g;
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0); exp_q.push_back(8'h10);
        exp_q.push_back(8'hA5); exp_q.push_back(TokStop);
        kick(1'b0, 7'h60, 8'h10, 8'hA5);
        wait_done(lat, seen);
        total++; if (!seen || lat != LatWrite)
                     $display("FAIL write_latency got %0d (seen=%0d) want %0d", lat, seen, LatWrite);
                 else passed++;
        total++; if (busy !== 1'b0) $display("FAIL write_busy_at_done got %b want 0", busy);
                 else passed++;
        total++; if (ack_err !== 1'b0) $display("FAIL write_ack_err got %b want 0", ack_err);
                 else passed++;
        @(posedge clk); #1;
        total++; if (done !== 1'b0) $display("FAIL write_done_pulse got %b want 0", done);
                 else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL write_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL write_token got %0d want %0d", g, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL write_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
    endtask

    task automatic test_read;
        int lat; bit seen; int e; int g;
        rd_byte = 8'h11;
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0); exp_q.push_back(8'h00);
        exp_q.push_back(TokStart); exp_q.push_back(8'hC1); exp_q.push_back(TokMNack);
        exp_q.push_back(TokStop);
        kick(1'b1, 7'h60, 8'h00, 8'h00);
        wait_done(lat, seen);
        total++; if (!seen || lat != LatRead)
                     $display("FAIL read_latency got %0d (seen=%0d) want %0d", lat, seen, LatRead);
                 else passed++;
        total++; if (rd_data !== 8'h11) $display("FAIL read_rd_data got %h want 11", rd_data);
                 else passed++;
        total++; if (ack_err !== 1'b0) $display("FAIL read_ack_err got %b want 0", ack_err);
                 else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL read_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL read_token got %0d want %0d", g, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL read_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
    endtask

    task automatic test_nack;
        int lat; bit seen; int e; int g;
        nack_idx = 0;
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0); exp_q.push_back(TokStop);
        kick(1'b0, 7'h60, 8'h20, 8'h5A);
        wait_done(lat, seen);
        total++; if (!seen || lat != LatNack)
                     $display("FAIL nack_latency got %0d (seen=%0d) want %0d", lat, seen, LatNack);
                 else passed++;
        total++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err got %b want 1", ack_err);
                 else passed++;
        total++; if (rd_data !== 8'h11) $display("FAIL nack_rd_data got %h want 11", rd_data);
                 else passed++;
        repeat (5) @(posedge clk); #1;
        total++; if (ack_err !== 1'b1) $display("FAIL nack_ack_err_held got %b want 1", ack_err);
                 else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL nack_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL nack_token got %0d want %0d", g, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL nack_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
        nack_idx = -1;
    endtask

    task automatic test_busy_ignore;
        int lat; bit seen; int e; int g;
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0); exp_q.push_back(8'h33);
        exp_q.push_back(8'h44); exp_q.push_back(TokStop);
        kick(1'b0, 7'h60, 8'h33, 8'h44);
        total++; if (ack_err !== 1'b0) $display("FAIL busy_ack_err_clear got %b want 0", ack_err);
                 else passed++;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); lat++; #1;
            if (lat == 40) begin
                start = 1'b1; rnw = 1'b1; dev_addr = 7'h22; reg_addr = 8'h55; wr_data = 8'h66;
            end
            if (lat == 44) start = 1'b0;
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        rnw = 1'b0;
        total++; if (!seen || lat != LatWrite)
                     $display("FAIL busy_latency got %0d (seen=%0d) want %0d", lat, seen, LatWrite);
                 else passed++;
        repeat (30) @(posedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL busy_no_second got %b want 0", busy);
                 else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL busy_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL busy_token got %0d want %0d", g, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL busy_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
    endtask

    task automatic test_reset_abort;
        int lat; bit seen; int e; int g;
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0);
        kick(1'b0, 7'h60, 8'h10, 8'hA5);
        // Cell 12 is a reg-byte bit cell; q1 keeps SCL low
        repeat (12 * 4 * CLK_DIV + 3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0)
                     $display("FAIL abort_release got scl_oe=%b sda_oe=%b want 0 0", scl_oe, sda_oe);
                 else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
                 else passed++;
        repeat (4) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL abort_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL abort_token got %0d want %0d", g, e); else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL abort_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
        exp_q.push_back(TokStart); exp_q.push_back(8'hC0); exp_q.push_back(8'h10);
        exp_q.push_back(8'hA5); exp_q.push_back(TokStop);
        kick(1'b0, 7'h60, 8'h10, 8'hA5);
        wait_done(lat, seen);
        total++; if (!seen || lat != LatWrite)
                     $display("FAIL abort_next_latency got %0d (seen=%0d) want %0d",
                              lat, seen, LatWrite);
                 else passed++;
        total++; if (ack_err !== 1'b0) $display("FAIL abort_next_ack_err got %b want 0", ack_err);
                 else passed++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); total++;
            if (obs_q.size() == 0) $display("FAIL abort_next_token got none want %0d", e);
            else begin
                g = obs_q.pop_front();
                if (g !== e) $display("FAIL abort_next_token got %0d want %0d", g, e);
                else passed++;
            end
        end
        total++; if (obs_q.size() != 0) $display("FAIL abort_next_extra got %0d tokens want 0",
                                                 obs_q.size());
                 else passed++;
        obs_q.delete();
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        nack_idx = -1;
        rd_byte  = 8'h00;
        start    = 1'b0;
        rnw      = 1'b0;
        dev_addr = 7'h00;
        reg_addr = 8'h00;
        wr_data  = 8'h00;
        reset_n  = 1'b1;
        test_reset;
        test_write;
        test_read;
        test_nack;
        test_busy_ignore;
        test_reset_abort;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
